mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface: takes load/store requests from the processor datapath over a valid/ready handshake.
- Sequences the strobes, address and data of the combinational, level-sensitive memory block, and returns captured load data or store completion.
- Sits between the processor's MEM-stage control and the memory block.
- Guarantees address/data are stable before and after every write strobe, and that a write strobe lasts exactly one cycle.

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: valid/ready load/store initiator that sequences the strobes of a combinational data memory.
// Optional feature macro MEM_SIGN_EXT_EN adds req_signed for sign-extending byte loads.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
`ifdef MEM_SIGN_EXT_EN
  input  logic              req_signed,
`endif
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WSTROBE,
    RSTROBE,
    HOLD,
    RESP,
    ERR
  } state_t;

  // One extra bit so the range check covers the full address width.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [3:0]      LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          wait_cnt;
  logic                last_wait;
  logic                accept;
  logic                addr_err;
  logic                op_write;
  logic                ext_bit;
  logic [DATA_W-1:0]   load_data;
`ifdef MEM_SIGN_EXT_EN
  logic                op_signed;
`endif

  assign accept    = req_valid && req_ready;
  assign addr_err  = {1'b0, req_addr} >= DEPTH_LIM;
  assign last_wait = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = addr_err ? ERR : SETUP;
      end
      SETUP:   state_d = op_write ? WSTROBE : RSTROBE;
      WSTROBE: state_d = HOLD;
      RSTROBE: if (last_wait) state_d = HOLD;
      HOLD:    state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free flop outputs
  // while still asserting in exactly the WSTROBE/RSTROBE cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      mem_write <= (state_d == WSTROBE);
      mem_read  <= (state_d == RSTROBE);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state_q == RSTROBE && !last_wait) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_comb begin
    ext_bit = 1'b0;
`ifdef MEM_SIGN_EXT_EN
    ext_bit = op_signed & mem_read_data[7];
`endif
    load_data = mem_read_data;
    if (mem_byte) load_data = {{(DATA_W-8){ext_bit}}, mem_read_data[7:0]};
  end

  // Rejected requests leave the memory-side address/data/byte untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_byte       <= 1'b0;
      op_write       <= 1'b0;
      rsp_rdata      <= '0;
`ifdef MEM_SIGN_EXT_EN
      op_signed      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_write <= req_write;
`ifdef MEM_SIGN_EXT_EN
        op_signed <= req_signed;
`endif
        if (addr_err) begin
          rsp_rdata <= '0;
        end else begin
          mem_address    <= req_addr;
          mem_write_data <= req_wdata;
          mem_byte       <= req_byte;
        end
      end
      if (state_q == RSTROBE && last_wait) rsp_rdata <= load_data;
      if (state_q == HOLD && op_write) rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic against a word-level memory model.
module tb_mem_access_unit;
  localparam int unsigned ADDR_W      = 18;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MEM_DEPTH   = 256;
  localparam int unsigned WAIT_CYCLES = 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_read_data;

  mem_access_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
`ifdef MEM_SIGN_EXT_EN
    .req_signed(req_signed),
`endif
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap_cnt = 0;

  // Memory block driven by the DUT strobes, and the bench's own view of memory contents.
  logic [31:0] mem_array [0:255];
  logic [31:0] ref_mem   [0:255];

  assign mem_read_data = mem_read ? mem_array[mem_address[7:0]] : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (mem_write)
      mem_array[mem_address[7:0]] <= mem_byte ? {mem_array[mem_address[7:0]][31:8], mem_write_data[7:0]}
                                              : mem_write_data;
  end

  always @(negedge clock) if (mem_read && mem_write) overlap_cnt++;

  logic [17:0] last_a;
  logic [31:0] last_d;
  logic        last_b;

  int          obs_lat, obs_rcyc, obs_wcyc, obs_wfirst, obs_rfirst;
  logic [31:0] obs_rdata, obs_hold;
  logic        obs_err, obs_stable, obs_busy, obs_ready_after;

  function automatic logic is_err(input logic [17:0] a);
    return 32'(a) >= MEM_DEPTH;
  endfunction

  function automatic logic [31:0] model_rdata(input logic w, input logic b, input logic s, input logic [17:0] a);
    logic [31:0] word;
    logic        sx;
    if (w || is_err(a)) return 32'h0;
    word = ref_mem[a[7:0]];
    if (!b) return word;
    sx = 1'b0;
`ifdef MEM_SIGN_EXT_EN
    sx = s & word[7];
`else
    if (s) sx = 1'b0;
`endif
    return sx ? (word | 32'hFFFF_FF00) : (word & 32'h0000_00FF);
  endfunction

  function automatic void model_store(input logic b, input logic [17:0] a, input logic [31:0] d);
    if (b) ref_mem[a[7:0]] = (ref_mem[a[7:0]] & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
    else   ref_mem[a[7:0]] = d;
  endfunction

  // Issue one request, release req_valid after acceptance and record what the DUT did.
  task automatic do_req(input logic w, input logic b, input logic s, input logic [17:0] a, input logic [31:0] d);
    logic [17:0] ea;
    logic [31:0] ed;
    logic        eb;
    int          k;
    ea = is_err(a) ? last_a : a;
    ed = is_err(a) ? last_d : d;
    eb = is_err(a) ? last_b : b;
    obs_lat = -1; obs_rcyc = 0; obs_wcyc = 0; obs_wfirst = -1; obs_rfirst = -1;
    obs_stable = 1'b1; obs_busy = 1'b1; obs_rdata = 'x; obs_err = 1'bx;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, want 1", req_ready, k);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    for (int n = 1; n <= 40 && obs_lat < 0; n++) begin
      @(negedge clock);
      if (mem_write) begin obs_wcyc++; if (obs_wfirst < 0) obs_wfirst = n; end
      if (mem_read)  begin obs_rcyc++; if (obs_rfirst < 0) obs_rfirst = n; end
      if (req_ready) obs_busy = 1'b0;
      if (mem_address !== ea || mem_write_data !== ed || mem_byte !== eb) obs_stable = 1'b0;
      if (rsp_valid) begin obs_lat = n; obs_rdata = rsp_rdata; obs_err = rsp_err; end
      if (n == 1) begin
        req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_addr = 18'($urandom); req_wdata = $urandom;
      end
    end
    @(negedge clock);
    obs_ready_after = req_ready;
    obs_hold = rsp_rdata;
    if (mem_address !== ea || mem_write_data !== ed || mem_byte !== eb || mem_read || mem_write) obs_stable = 1'b0;
    last_a = ea; last_d = ed; last_b = eb;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'($urandom); req_byte = 1'($urandom);
      req_addr = 18'($urandom); req_wdata = $urandom;
    end
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL reset_rsp: got valid=%0b err=%0b want 0 0", rsp_valid, rsp_err); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else n_pass++;
    n_checks++;
    if ({mem_address, mem_write_data, mem_read, mem_write, mem_byte} !== '0)
      $display("FAIL reset_mem: got addr=%h data=%h rd=%0b wr=%0b byte=%0b want all 0",
               mem_address, mem_write_data, mem_read, mem_write, mem_byte);
    else n_pass++;
    req_valid = 1'b0;
    reset_n = 1'b1;
    last_a = '0; last_d = '0; last_b = 1'b0;
  endtask

  task automatic test_store_word;
    do_req(1'b1, 1'b0, 1'b0, 18'h00010, 32'hDEADBEEF);
    model_store(1'b0, 18'h00010, 32'hDEADBEEF);
    n_checks++; if (obs_wcyc !== 1) $display("FAIL store_wr_cycles: got %0d want 1", obs_wcyc); else n_pass++;
    n_checks++; if (obs_wfirst !== 2) $display("FAIL store_wr_pos: got %0d want 2", obs_wfirst); else n_pass++;
    n_checks++; if (obs_rcyc !== 0) $display("FAIL store_rd_cycles: got %0d want 0", obs_rcyc); else n_pass++;
    n_checks++; if (obs_stable !== 1'b1) $display("FAIL store_stable: got %0b want 1", obs_stable); else n_pass++;
    n_checks++; if (obs_lat !== 4) $display("FAIL store_lat: got %0d want 4", obs_lat); else n_pass++;
    n_checks++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) $display("FAIL store_rsp: got rdata=%h err=%0b want 0 0", obs_rdata, obs_err); else n_pass++;
  endtask

  task automatic test_load_word;
    do_req(1'b0, 1'b0, 1'b0, 18'h00010, $urandom);
    n_checks++; if (obs_rcyc !== int'(WAIT_CYCLES)) $display("FAIL load_rd_cycles: got %0d want %0d", obs_rcyc, WAIT_CYCLES); else n_pass++;
    n_checks++; if (obs_rfirst !== 2) $display("FAIL load_rd_pos: got %0d want 2", obs_rfirst); else n_pass++;
    n_checks++; if (obs_lat !== 3 + int'(WAIT_CYCLES)) $display("FAIL load_lat: got %0d want %0d", obs_lat, 3 + WAIT_CYCLES); else n_pass++;
    n_checks++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", obs_rdata); else n_pass++;
    n_checks++; if (obs_hold !== 32'hDEADBEEF) $display("FAIL load_hold: got %h want deadbeef", obs_hold); else n_pass++;
  endtask

  task automatic test_byte_load;
    mem_array[8'h20] = 32'h123456F0; ref_mem[8'h20] = 32'h123456F0;
    do_req(1'b0, 1'b1, 1'b0, 18'h00020, $urandom);
    n_checks++; if (obs_rdata !== 32'h000000F0) $display("FAIL byte_zext: got %h want 000000f0", obs_rdata); else n_pass++;
    n_checks++; if (obs_stable !== 1'b1) $display("FAIL byte_stable: got %0b want 1", obs_stable); else n_pass++;
    do_req(1'b0, 1'b1, 1'b1, 18'h00020, $urandom);
`ifdef MEM_SIGN_EXT_EN
    n_checks++; if (obs_rdata !== 32'hFFFFFFF0) $display("FAIL byte_sext: got %h want fffffff0", obs_rdata); else n_pass++;
`else
    n_checks++; if (obs_rdata !== 32'h000000F0) $display("FAIL byte_signed_ignored: got %h want 000000f0", obs_rdata); else n_pass++;
`endif
    do_req(1'b0, 1'b0, 1'b1, 18'h00020, $urandom);
    n_checks++; if (obs_rdata !== 32'h123456F0) $display("FAIL word_signed: got %h want 123456f0", obs_rdata); else n_pass++;
  endtask

  task automatic test_boundary;
    do_req(1'b0, 1'b0, 1'b0, 18'h000FF, $urandom);
    n_checks++; if (obs_lat !== 3 + int'(WAIT_CYCLES) || obs_err !== 1'b0) $display("FAIL bound_ff: got lat=%0d err=%0b want %0d 0", obs_lat, obs_err, 3 + WAIT_CYCLES); else n_pass++;
    n_checks++; if (obs_rdata !== ref_mem[8'hFF]) $display("FAIL bound_ff_rdata: got %h want %h", obs_rdata, ref_mem[8'hFF]); else n_pass++;
    do_req(1'b0, 1'b0, 1'b0, 18'h00100, $urandom);
    n_checks++; if (obs_lat !== 1 || obs_err !== 1'b1) $display("FAIL bound_100: got lat=%0d err=%0b want 1 1", obs_lat, obs_err); else n_pass++;
    n_checks++; if (obs_rdata !== 32'h0) $display("FAIL bound_100_rdata: got %h want 0", obs_rdata); else n_pass++;
    n_checks++; if (obs_rcyc + obs_wcyc !== 0) $display("FAIL bound_100_strobes: got %0d want 0", obs_rcyc + obs_wcyc); else n_pass++;
    n_checks++; if (obs_stable !== 1'b1) $display("FAIL bound_100_stable: got %0b want 1", obs_stable); else n_pass++;
    // Bits above the implemented depth must not be dropped.
    do_req(1'b1, 1'b0, 1'b0, 18'h20005, $urandom);
    n_checks++; if (obs_err !== 1'b1 || obs_wcyc !== 0) $display("FAIL bound_high_store: got err=%0b wr=%0d want 1 0", obs_err, obs_wcyc); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [17:0] a;
    logic [31:0] d;
    int          k, rsp1, rsp2, pulses, ready_rise;
    logic        busy_ok;
    logic [31:0] rd2;
    a = 18'($urandom_range(0, 255)); d = $urandom;
    rsp1 = -1; rsp2 = -1; pulses = 0; ready_rise = -1; busy_ok = 1'b1; rd2 = 'x;
    overlap_cnt = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clock); k++; end
    @(posedge clock);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clock);
      if (rsp_valid) begin
        pulses++;
        if (rsp1 < 0) rsp1 = n; else if (rsp2 < 0) begin rsp2 = n; rd2 = rsp_rdata; end
      end
      if (n <= 4 && req_ready) busy_ok = 1'b0;
      if (req_ready && ready_rise < 0) ready_rise = n;
      if (n == 1) begin req_write = 1'b0; req_addr = a; req_wdata = $urandom; end
      if (n == 6) req_valid = 1'b0;
    end
    model_store(1'b0, a, d);
    last_a = a; last_d = d; last_b = 1'b0;
    n_checks++; if (rsp1 !== 4) $display("FAIL b2b_rsp1: got %0d want 4", rsp1); else n_pass++;
    n_checks++; if (busy_ok !== 1'b1 || ready_rise !== 5) $display("FAIL b2b_ready: got busy_ok=%0b rise=%0d want 1 5", busy_ok, ready_rise); else n_pass++;
    n_checks++; if (rsp2 !== 5 + 3 + int'(WAIT_CYCLES)) $display("FAIL b2b_rsp2: got %0d want %0d", rsp2, 8 + WAIT_CYCLES); else n_pass++;
    n_checks++; if (rd2 !== d) $display("FAIL b2b_rdata: got %h want %h", rd2, d); else n_pass++;
    n_checks++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else n_pass++;
    n_checks++; if (overlap_cnt !== 0) $display("FAIL b2b_overlap: got %0d want 0", overlap_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    logic [17:0] a;
    logic [31:0] d;
    int          k, pulses;
    logic        ready_ok, wr_seen;
    a = 18'($urandom_range(0, 255)); d = $urandom;
    pulses = 0; ready_ok = 1'b1; wr_seen = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = a; req_wdata = d;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clock); k++; end
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;
    @(negedge clock); wr_seen = mem_write; reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (wr_seen !== 1'b1) $display("FAIL rst_wr_before: got %0b want 1", wr_seen); else n_pass++;
    n_checks++; if (mem_write !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rst_wr_drop: got wr=%0b rsp=%0b want 0 0", mem_write, rsp_valid); else n_pass++;
    n_checks++; if (mem_address !== '0) $display("FAIL rst_addr: got %h want 0", mem_address); else n_pass++;
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
      if (!req_ready) ready_ok = 1'b0;
    end
    n_checks++; if (pulses !== 0) $display("FAIL rst_no_rsp: got %0d pulses want 0", pulses); else n_pass++;
    n_checks++; if (ready_ok !== 1'b1) $display("FAIL rst_ready: got %0b want 1", ready_ok); else n_pass++;
    // The strobe was high for a full cycle before reset was sampled, so the word landed.
    model_store(1'b0, a, d);
    last_a = '0; last_d = '0; last_b = 1'b0;
  endtask

  task automatic test_random;
    logic        w, b, s, ee;
    logic [17:0] a;
    logic [31:0] d, er;
    int          el, sel, mism;
    overlap_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom); b = 1'($urandom); s = 1'($urandom); d = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 18'h000FF;
      else if (sel == 1) a = 18'h00100;
      else if (sel == 2) a = 18'($urandom_range(256, 262143));
      else               a = 18'($urandom_range(0, 255));
      ee = is_err(a);
      el = ee ? 1 : (w ? 4 : 3 + int'(WAIT_CYCLES));
      er = model_rdata(w, b, s, a);
      do_req(w, b, s, a, d);
      if (!ee && w) model_store(b, a, d);
      n_checks++; if (obs_lat !== el) $display("FAIL rnd%0d_lat: got %0d want %0d", i, obs_lat, el); else n_pass++;
      n_checks++; if (obs_err !== ee) $display("FAIL rnd%0d_err: got %0b want %0b", i, obs_err, ee); else n_pass++;
      n_checks++; if (obs_rdata !== er) $display("FAIL rnd%0d_rdata: got %h want %h", i, obs_rdata, er); else n_pass++;
      n_checks++; if (obs_hold !== er) $display("FAIL rnd%0d_hold: got %h want %h", i, obs_hold, er); else n_pass++;
      n_checks++;
      if (obs_rcyc !== ((!ee && !w) ? int'(WAIT_CYCLES) : 0) || obs_wcyc !== ((!ee && w) ? 1 : 0))
        $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d want rd=%0d wr=%0d", i, obs_rcyc, obs_wcyc,
                 (!ee && !w) ? int'(WAIT_CYCLES) : 0, (!ee && w) ? 1 : 0);
      else n_pass++;
      n_checks++; if (obs_stable !== 1'b1) $display("FAIL rnd%0d_stable: got %0b want 1", i, obs_stable); else n_pass++;
      n_checks++; if (obs_busy !== 1'b1 || obs_ready_after !== 1'b1) $display("FAIL rnd%0d_ready: got busy=%0b after=%0b want 1 1", i, obs_busy, obs_ready_after); else n_pass++;
    end
    n_checks++; if (overlap_cnt !== 0) $display("FAIL rnd_overlap: got %0d want 0", overlap_cnt); else n_pass++;
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem_array[i] !== ref_mem[i]) mism++;
    n_checks++; if (mism !== 0) $display("FAIL mem_contents: got %0d differing words want 0", mism); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = $urandom;
      ref_mem[i]   = mem_array[i];
    end
    test_reset();
    test_store_word();
    test_load_word();
    test_byte_load();
    test_boundary();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
